// File: rtl/gmii_rx_framer.sv
// GMII receive framer: strips preamble/SFD, forwards frame bytes one cycle late,
// checks FCS, length and rx_er, and counts aborted preambles.
module gmii_rx_framer #(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1522
) (
  input  logic        gmii_clk,
  input  logic        rst,
  input  logic        gmii_rx_dv,
  input  logic        gmii_rx_er,
  input  logic [7:0]  gmii_rxd,
  output logic        out_ctrl,
  output logic [7:0]  out_data,
  output logic        out_sof,
  output logic        out_eof,
  output logic        stat_good,
  output logic        stat_crc_err,
  output logic        stat_rx_err,
  output logic        stat_len_err,
  output logic [15:0] stat_len,
  output logic [15:0] drop_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PRE  = 2'd1,
    S_DATA = 2'd2,
    S_DROP = 2'd3
  } state_t;

  localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
  localparam logic [15:0] MIN_L       = 16'(MIN_LEN);
  localparam logic [15:0] MAX_L       = 16'(MAX_LEN);

  state_t      state_q, state_d;
  logic [31:0] crc_q, crc_d;
  logic [15:0] len_q, len_d;
  logic        rxerr_q, rxerr_d;
  logic        first_q, first_d;
  logic        out_ctrl_q, out_ctrl_d;
  logic [7:0]  out_data_q, out_data_d;
  logic        out_sof_q, out_sof_d;
  logic        out_eof_q, out_eof_d;
  logic        good_q, good_d;
  logic        crc_err_q, crc_err_d;
  logic        rx_err_q, rx_err_d;
  logic        len_err_q, len_err_d;
  logic [15:0] stat_len_q, stat_len_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic        drop_inc;
  logic        fcs_bad;
  logic        len_bad;

  // Reflected CRC-32, data consumed LSB first.
  function automatic logic [31:0] crc_byte(input logic [31:0] c_in, input logic [7:0] d);
    logic [31:0] c;
    c = c_in;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ d[i]) c = (c >> 1) ^ CRC_POLY;
      else             c = c >> 1;
    end
    return c;
  endfunction

  assign fcs_bad = (crc_q != CRC_RESIDUE);
  assign len_bad = (len_q < MIN_L) || (len_q > MAX_L);

  always_comb begin
    state_d    = state_q;
    crc_d      = crc_q;
    len_d      = len_q;
    rxerr_d    = rxerr_q;
    first_d    = first_q;
    out_ctrl_d = 1'b0;
    out_data_d = 8'h00;
    out_sof_d  = 1'b0;
    out_eof_d  = 1'b0;
    good_d     = good_q;
    crc_err_d  = crc_err_q;
    rx_err_d   = rx_err_q;
    len_err_d  = len_err_q;
    stat_len_d = stat_len_q;
    drop_inc   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (gmii_rx_dv) begin
          if (gmii_rxd == 8'h55) begin
            state_d = S_PRE;
          end else begin
            state_d  = S_DROP;
            drop_inc = 1'b1;
          end
        end
      end
      S_PRE: begin
        if (!gmii_rx_dv) begin
          state_d  = S_IDLE;
          drop_inc = 1'b1;
        end else if (gmii_rx_er) begin
          state_d  = S_DROP;
          drop_inc = 1'b1;
        end else if (gmii_rxd == 8'h55) begin
          state_d = S_PRE;
        end else if (gmii_rxd == 8'hD5) begin
          state_d = S_DATA;
          crc_d   = 32'hFFFF_FFFF;
          len_d   = 16'd0;
          rxerr_d = 1'b0;
          first_d = 1'b1;
        end else begin
          state_d  = S_DROP;
          drop_inc = 1'b1;
        end
      end
      S_DATA: begin
        if (gmii_rx_dv) begin
          out_ctrl_d = 1'b1;
          out_data_d = gmii_rxd;
          out_sof_d  = first_q;
          first_d    = 1'b0;
          crc_d      = crc_byte(crc_q, gmii_rxd);
          if (len_q != 16'hFFFF) len_d = len_q + 16'd1;
          if (gmii_rx_er) rxerr_d = 1'b1;
        end else begin
          // The last byte is already in crc_q/len_q, so stats resolve here.
          state_d    = S_IDLE;
          out_eof_d  = 1'b1;
          stat_len_d = len_q;
          crc_err_d  = fcs_bad;
          rx_err_d   = rxerr_q;
          len_err_d  = len_bad;
          good_d     = !fcs_bad && !rxerr_q && !len_bad;
        end
      end
      S_DROP: begin
        if (!gmii_rx_dv) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    drop_cnt_d = drop_cnt_q;
    if (drop_inc && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
  end

  always_ff @(posedge gmii_clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      crc_q      <= 32'd0;
      len_q      <= 16'd0;
      rxerr_q    <= 1'b0;
      first_q    <= 1'b0;
      out_ctrl_q <= 1'b0;
      out_data_q <= 8'h00;
      out_sof_q  <= 1'b0;
      out_eof_q  <= 1'b0;
      good_q     <= 1'b0;
      crc_err_q  <= 1'b0;
      rx_err_q   <= 1'b0;
      len_err_q  <= 1'b0;
      stat_len_q <= 16'd0;
      drop_cnt_q <= 16'd0;
    end else begin
      state_q    <= state_d;
      crc_q      <= crc_d;
      len_q      <= len_d;
      rxerr_q    <= rxerr_d;
      first_q    <= first_d;
      out_ctrl_q <= out_ctrl_d;
      out_data_q <= out_data_d;
      out_sof_q  <= out_sof_d;
      out_eof_q  <= out_eof_d;
      good_q     <= good_d;
      crc_err_q  <= crc_err_d;
      rx_err_q   <= rx_err_d;
      len_err_q  <= len_err_d;
      stat_len_q <= stat_len_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign out_ctrl     = out_ctrl_q;
  assign out_data     = out_data_q;
  assign out_sof      = out_sof_q;
  assign out_eof      = out_eof_q;
  assign stat_good    = good_q;
  assign stat_crc_err = crc_err_q;
  assign stat_rx_err  = rx_err_q;
  assign stat_len_err = len_err_q;
  assign stat_len     = stat_len_q;
  assign drop_cnt     = drop_cnt_q;

endmodule

// File: tb/tb_gmii_rx_framer.sv
// Bench for gmii_rx_framer: table of frame scenarios, hand-written abort/reset
// sequences and random frames checked against a frame-level reference model.
module tb_gmii_rx_framer;

  logic        gmii_clk = 1'b0;
  logic        rst;
  logic        dv, er;
  logic [7:0]  rxd;
  logic        out_ctrl, out_sof, out_eof;
  logic [7:0]  out_data;
  logic        stat_good, stat_crc_err, stat_rx_err, stat_len_err;
  logic [15:0] stat_len, drop_cnt;

  gmii_rx_framer #(.MIN_LEN(64), .MAX_LEN(1522)) dut (
    .gmii_clk(gmii_clk), .rst(rst),
    .gmii_rx_dv(dv), .gmii_rx_er(er), .gmii_rxd(rxd),
    .out_ctrl(out_ctrl), .out_data(out_data), .out_sof(out_sof), .out_eof(out_eof),
    .stat_good(stat_good), .stat_crc_err(stat_crc_err), .stat_rx_err(stat_rx_err),
    .stat_len_err(stat_len_err), .stat_len(stat_len), .drop_cnt(drop_cnt)
  );

  always #5 gmii_clk = ~gmii_clk;

  int cyc = 0;
  always @(posedge gmii_clk) cyc <= cyc + 1;

  int tests = 0, fails = 0, viol = 0;

  typedef struct { int cyc; logic [7:0] d; } exp_byte_t;
  typedef struct { int len; bit crc_err; bit rx_err; bit len_err; bit good; } exp_frame_t;
  typedef struct {
    int n; int pre; int flip; int er_idx;
    int len; bit good; bit crc_err; bit rx_err; bit len_err;
  } vec_t;

  exp_byte_t  eb_q[$];
  exp_frame_t ef_q[$];
  logic [7:0] frm[$];
  int         exp_drop = 0;

  int  eof_count = 0;
  bit  first_pending = 1'b1;
  bit  prev_ctrl = 1'b0;
  int  l_len; bit l_good, l_crc, l_rxe, l_le;

  task automatic check(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic note_viol(string name, int act, int exp);
    viol++;
    $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
  endtask

  // Stream monitor: byte order/latency, sof/eof placement, stat hold.
  always @(negedge gmii_clk) begin
    if (rst) begin
      first_pending = 1'b1;
      prev_ctrl = 1'b0;
      l_len = 0; l_good = 0; l_crc = 0; l_rxe = 0; l_le = 0;
    end else begin
      if (!out_ctrl && out_data != 8'h00) note_viol("idle_data_nonzero", out_data, 0);
      if (out_ctrl) begin
        if (eb_q.size() == 0) note_viol("unexpected_byte", out_data, -1);
        else begin
          exp_byte_t e;
          e = eb_q.pop_front();
          if (e.cyc != cyc) note_viol("byte_latency", cyc, e.cyc);
          if (e.d != out_data) note_viol("byte_data", out_data, e.d);
        end
        if (out_sof != first_pending) note_viol("sof", out_sof, first_pending);
        first_pending = 1'b0;
      end else if (out_sof) note_viol("sof_without_ctrl", 1, 0);
      if (out_eof) begin
        if (out_ctrl) note_viol("eof_with_ctrl", 1, 0);
        if (ef_q.size() == 0) note_viol("unexpected_eof", 1, 0);
        else begin
          exp_frame_t f;
          f = ef_q.pop_front();
          check("eof_after_last_byte", prev_ctrl, f.len > 0);
          check("stat_len", stat_len, f.len);
          check("stat_crc_err", stat_crc_err, f.crc_err);
          check("stat_rx_err", stat_rx_err, f.rx_err);
          check("stat_len_err", stat_len_err, f.len_err);
          check("stat_good", stat_good, f.good);
        end
        eof_count++;
        l_len = stat_len; l_good = stat_good; l_crc = stat_crc_err;
        l_rxe = stat_rx_err; l_le = stat_len_err;
        first_pending = 1'b1;
      end else if (stat_len != l_len || stat_good != l_good || stat_crc_err != l_crc ||
                   stat_rx_err != l_rxe || stat_len_err != l_le) begin
        note_viol("stat_hold", stat_len, l_len);
      end
      prev_ctrl = out_ctrl;
    end
  end

  // Ethernet FCS over frm[0..upto-1], as transmitted (complemented).
  function automatic logic [31:0] eth_fcs(int upto);
    logic [31:0] c = 32'hFFFF_FFFF;
    for (int i = 0; i < upto; i++)
      for (int b = 0; b < 8; b++) begin
        bit fb = c[0] ^ frm[i][b];
        c = c >> 1;
        if (fb) c = c ^ 32'hEDB88320;
      end
    return ~c;
  endfunction

  function automatic exp_frame_t model(int er_idx);
    exp_frame_t f;
    int n = frm.size();
    bit fcs_ok = 1'b0;
    if (n >= 4) fcs_ok = (eth_fcs(n - 4) == {frm[n-1], frm[n-2], frm[n-3], frm[n-4]});
    f.len     = n;
    f.crc_err = !fcs_ok;
    f.rx_err  = (er_idx >= 0) && (er_idx < n);
    f.len_err = (n < 64) || (n > 1522);
    f.good    = !f.crc_err && !f.rx_err && !f.len_err;
    return f;
  endfunction

  task automatic build(int n);
    logic [31:0] c;
    frm.delete();
    if (n >= 4) begin
      for (int i = 0; i < n - 4; i++) frm.push_back(8'($urandom));
      c = eth_fcs(n - 4);
      frm.push_back(c[7:0]);   frm.push_back(c[15:8]);
      frm.push_back(c[23:16]); frm.push_back(c[31:24]);
    end else begin
      for (int i = 0; i < n; i++) frm.push_back(8'($urandom));
    end
  endtask

  task automatic tick();
    @(posedge gmii_clk); #1;
  endtask

  task automatic drive(bit v, bit e, logic [7:0] d);
    dv = v; er = e; rxd = d;
    tick();
  endtask

  task automatic send(int pre, int er_idx, int gap);
    ef_q.push_back(model(er_idx));
    for (int i = 0; i < pre; i++) drive(1, 0, 8'h55);
    drive(1, 0, 8'hD5);
    for (int i = 0; i < frm.size(); i++) begin
      exp_byte_t e;
      e.cyc = cyc + 1; e.d = frm[i];
      eb_q.push_back(e);
      drive(1, (i == er_idx), frm[i]);
    end
    for (int i = 0; i < gap; i++) drive(0, 0, 8'h00);
  endtask

  vec_t tbl[8];

  initial begin
    int e0;
    tbl[0] = '{n:64,   pre:7, flip:-1, er_idx:-1, len:64,   good:1, crc_err:0, rx_err:0, len_err:0};
    tbl[1] = '{n:64,   pre:7, flip:20, er_idx:-1, len:64,   good:0, crc_err:1, rx_err:0, len_err:0};
    tbl[2] = '{n:64,   pre:7, flip:-1, er_idx:10, len:64,   good:0, crc_err:0, rx_err:1, len_err:0};
    tbl[3] = '{n:60,   pre:7, flip:-1, er_idx:-1, len:60,   good:0, crc_err:0, rx_err:0, len_err:1};
    tbl[4] = '{n:1523, pre:7, flip:-1, er_idx:-1, len:1523, good:0, crc_err:0, rx_err:0, len_err:1};
    tbl[5] = '{n:1522, pre:7, flip:-1, er_idx:-1, len:1522, good:1, crc_err:0, rx_err:0, len_err:0};
    tbl[6] = '{n:0,    pre:7, flip:-1, er_idx:-1, len:0,    good:0, crc_err:1, rx_err:0, len_err:1};
    tbl[7] = '{n:64,   pre:1, flip:-1, er_idx:-1, len:64,   good:1, crc_err:0, rx_err:0, len_err:0};

    rst = 1'b1; dv = 0; er = 0; rxd = 8'h00;
    repeat (3) tick();
    check("reset_out_ctrl", out_ctrl, 0);
    check("reset_out_data", out_data, 0);
    check("reset_sof_eof", {out_sof, out_eof}, 0);
    check("reset_stats", {stat_good, stat_crc_err, stat_rx_err, stat_len_err}, 0);
    check("reset_stat_len", stat_len, 0);
    check("reset_drop_cnt", drop_cnt, 0);
    rst = 1'b0;
    repeat (2) tick();

    for (int i = 0; i < 8; i++) begin
      build(tbl[i].n);
      if (tbl[i].flip >= 0) frm[tbl[i].flip] = frm[tbl[i].flip] ^ 8'h08;
      e0 = eof_count;
      send(tbl[i].pre, tbl[i].er_idx, 3);
      check($sformatf("tbl%0d_eof_seen", i), eof_count - e0, 1);
      check($sformatf("tbl%0d_len", i), l_len, tbl[i].len);
      check($sformatf("tbl%0d_good", i), l_good, tbl[i].good);
      check($sformatf("tbl%0d_crc_err", i), l_crc, tbl[i].crc_err);
      check($sformatf("tbl%0d_rx_err", i), l_rxe, tbl[i].rx_err);
      check($sformatf("tbl%0d_len_err", i), l_le, tbl[i].len_err);
    end
    check("drop_after_table", drop_cnt, exp_drop);

    // Preamble corrupted by 0xAA, dv held for 20 more cycles.
    drive(1, 0, 8'h55); drive(1, 0, 8'h55); drive(1, 0, 8'hAA);
    for (int i = 0; i < 20; i++) drive(1, 0, 8'($urandom));
    drive(0, 0, 8'h00); drive(0, 0, 8'h00);
    exp_drop++;
    check("drop_bad_preamble", drop_cnt, exp_drop);

    // Non-preamble byte straight from idle.
    drive(1, 0, 8'h12);
    repeat (3) drive(1, 0, 8'hD5);
    drive(0, 0, 8'h00);
    exp_drop++;
    check("drop_idle_garbage", drop_cnt, exp_drop);

    // dv falls during preamble.
    drive(1, 0, 8'h55); drive(1, 0, 8'h55); drive(0, 0, 8'h00); drive(0, 0, 8'h00);
    exp_drop++;
    check("drop_pre_dv_low", drop_cnt, exp_drop);

    // rx_er during preamble, then a would-be SFD that must be ignored.
    drive(1, 0, 8'h55); drive(1, 1, 8'h55); drive(1, 0, 8'hD5);
    repeat (4) drive(1, 0, 8'h33);
    drive(0, 0, 8'h00);
    exp_drop++;
    check("drop_pre_rx_er", drop_cnt, exp_drop);

    // Reset at byte 30 with dv still high, released mid-frame.
    build(64);
    frm[32] = 8'hA3;
    for (int i = 0; i < 7; i++) drive(1, 0, 8'h55);
    drive(1, 0, 8'hD5);
    for (int i = 0; i < 30; i++) begin
      exp_byte_t e;
      e.cyc = cyc + 1; e.d = frm[i];
      eb_q.push_back(e);
      drive(1, 0, frm[i]);
    end
    ef_q.push_back(model(-1));
    check("pre_reset_ctrl", out_ctrl, 1);
    rst = 1'b1;
    #1;
    check("rst_async_ctrl", out_ctrl, 0);
    check("rst_async_data", out_data, 0);
    check("rst_async_drop", drop_cnt, 0);
    check("rst_async_eof", out_eof, 0);
    eb_q.delete(); ef_q.delete();
    exp_drop = 0;
    dv = 1; rxd = frm[30]; tick();
    dv = 1; rxd = frm[31]; tick();
    rst = 1'b0;
    for (int i = 32; i < 64; i++) drive(1, 0, frm[i]);
    drive(0, 0, 8'h00); drive(0, 0, 8'h00);
    exp_drop++;
    check("post_reset_drop", drop_cnt, exp_drop);
    check("post_reset_no_eof", out_eof, 0);
    build(64);
    e0 = eof_count;
    send(7, -1, 3);
    check("post_reset_eof_seen", eof_count - e0, 1);
    check("post_reset_good", l_good, 1);

    // Random frames, some back-to-back (dv returns in the out_eof cycle).
    for (int k = 0; k < 30; k++) begin
      int n, pre, er_idx, gap;
      n = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1520, 1524)) : int'($urandom_range(1, 100));
      pre = $urandom_range(1, 7);
      er_idx = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, n + 2)) : -1;
      gap = $urandom_range(1, 3);
      build(n);
      if ($urandom_range(0, 4) == 0) begin
        int idx = $urandom_range(0, n - 1);
        frm[idx] = frm[idx] ^ (8'h01 << $urandom_range(0, 7));
      end
      send(pre, er_idx, gap);
    end
    repeat (5) drive(0, 0, 8'h00);
    check("random_drop_unchanged", drop_cnt, exp_drop);

    check("pending_frames", ef_q.size(), 0);
    check("pending_bytes", eb_q.size(), 0);
    check("stream_violations", viol, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/gmii_rx_framer.md
GMII_RX_FRAMER -- requirements
Module: gmii_rx_framer

Interface
REQ-001 Parameter MIN_LEN, default 64, minimum legal frame length in bytes, destination address through FCS inclusive.
REQ-002 Parameter MAX_LEN, default 1522, maximum legal frame length in bytes.
REQ-003 gmii_clk  input  1  receive clock; all logic is on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 gmii_rx_dv  input  1  GMII receive data valid.
REQ-006 gmii_rx_er  input  1  GMII receive error.
REQ-007 gmii_rxd  input  8  GMII receive data.
REQ-008 out_ctrl  output  1  high for each forwarded frame byte after SFD; drives tsu_queue gmii_ctrl.
REQ-009 out_data  output  8  forwarded byte; drives tsu_queue gmii_data.
REQ-010 out_sof  output  1  one-cycle pulse coincident with the first out_ctrl byte.
REQ-011 out_eof  output  1  one-cycle pulse in the cycle after the last out_ctrl byte.
REQ-012 stat_good  output  1  valid with out_eof: FCS correct, no rx_er, and MIN_LEN<=len<=MAX_LEN.
REQ-013 stat_crc_err, stat_rx_err, stat_len_err  output  1 each  causes, valid with out_eof.
REQ-014 stat_len  output  16  forwarded byte count including FCS, valid with out_eof.
REQ-015 drop_cnt  output  16  count of aborted preambles.

Function
REQ-016 States SHALL be IDLE, PRE, DATA, DROP.
REQ-017 IDLE: dv=1 & rxd=0x55 SHALL go to PRE; dv=1 with any other byte SHALL go to DROP and increment drop_cnt.
REQ-018 PRE: dv=1 & rxd=0x55 SHALL stay in PRE; dv=1 & rxd=0xD5 SHALL go to DATA; any other byte, or rx_er=1, SHALL go to DROP and increment drop_cnt; dv=0 SHALL go to IDLE and increment drop_cnt.
REQ-019 DATA: each byte with dv=1 SHALL appear on out_data with out_ctrl=1 exactly 1 cycle later; dv=0 SHALL return to IDLE.
REQ-020 DROP: no output; dv=0 SHALL return to IDLE.
REQ-021 Preamble and SFD bytes SHALL never be forwarded; out_data SHALL be 0x00 whenever out_ctrl=0.
REQ-022 The CRC register SHALL be set to 0xFFFFFFFF on the SFD and updated per forwarded byte using reflected polynomial 0xEDB88320, LSB first.
REQ-023 At end of frame, stat_crc_err SHALL be 1 iff the register is not equal to residue 0xDEBB20E3.
REQ-024 stat_rx_err SHALL be 1 if rx_er was high on any DATA-state byte.
REQ-025 While in DATA, rx_er SHALL NOT stop forwarding.
REQ-026 stat_len SHALL saturate at 0xFFFF.
REQ-027 stat_len_err SHALL be 1 iff len<MIN_LEN or len>MAX_LEN.
REQ-028 All stat_* outputs SHALL hold their values until the next out_eof.
REQ-029 drop_cnt SHALL saturate at 0xFFFF.
REQ-030 A frame of 0 bytes after SFD (SFD then dv=0) SHALL give out_eof with stat_len=0 and stat_len_err=1, and no out_sof.
REQ-031 dv=1 arriving in the same cycle as out_eof SHALL be handled as a new IDLE evaluation.

Reset
REQ-032 On rst, state SHALL be IDLE, and all outputs, the CRC register and all counters SHALL be 0.
REQ-033 If rst deasserts while dv=1 mid-frame, the first byte seen in IDLE SHALL be evaluated per REQ-017; a non-0x55 byte SHALL go to DROP.
REQ-034 Reset mid-frame SHALL drop out_ctrl in the cycle of assertion, with no out_eof generated.

Verification
REQ-035 7x0x55 + 0xD5 + 64-byte frame with valid FCS -> out_sof at first byte; 64 out_ctrl cycles; out_eof with stat_good=1, stat_len=64.
REQ-036 Same frame with one payload bit flipped -> stat_crc_err=1, stat_good=0, stat_len=64.
REQ-037 rx_er pulsed on byte 10 of a valid frame -> all 64 bytes forwarded; stat_rx_err=1, stat_good=0.
REQ-038 Preamble 0x55,0x55,0xAA then dv held for 20 cycles -> no out_ctrl; drop_cnt=1.
REQ-039 Valid 60-byte and 1523-byte frames -> stat_len_err=1 with stat_len=60 and 1523 respectively.
REQ-040 rst asserted at byte 30 of a frame and released with dv still high -> outputs 0; DROP until dv=0; next valid frame gives stat_good=1.
